instr_issue_queue: RTL and testbench

//  Upstream feeder for the datapath controller FSM. Buffers 16-bit instructions in a small FIFO.

---
 rtl/instr_issue_queue.sv | 183 ++++++++++++++++++
 tb/tb_instr_issue_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers 16-bit instructions in a small FIFO and issues
// them one at a time to the datapath controller, decoding fields of the current one.
module instr_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [15:0]                in_instr,
  output logic                       in_ready,
  input  logic                       ctrl_waiting,
  input  logic [1:0]                 reg_sel,
  output logic                       ctrl_start,
  output logic [2:0]                 opcode,
  output logic [1:0]                 ALU_op,
  output logic [1:0]                 shift_op,
  output logic [2:0]                 r_addr,
  output logic [15:0]                sximm8,
  output logic [15:0]                sximm5,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       busy,
  output logic [CNT_W-1:0]           issued_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN0  = 2'd2,
    EXEC  = 2'd3
  } state_t;

  logic [15:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_next_s;
  logic              in_ready_r;
  state_t            state_r;
  state_t            state_next_s;
  logic              run_wait_r;
  logic              run_wait_next_s;
  logic [15:0]       cur_instr_r;
  logic              ctrl_start_r;
  logic              busy_r;
  logic [CNT_W-1:0]  issued_count_r;
  logic              push_s;
  logic              pop_s;
  logic [2:0]        r_addr_s;

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = (state_r == IDLE) & (fill_r != {FILL_W{1'b0}}) & ctrl_waiting;

  // Occupancy after this edge's push/pop
  always_comb begin
    fill_next_s = fill_r;
    case ({push_s, pop_s})
      2'b10:   fill_next_s = fill_r + FILL_W'(1);
      2'b01:   fill_next_s = fill_r - FILL_W'(1);
      default: fill_next_s = fill_r;
    endcase
  end

  // FIFO storage; the tail slot is written on every accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_instr;
      end
    end
  end

  // FIFO pointers, fill and the registered ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fill_r     <= {FILL_W{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      fill_r     <= fill_next_s;
      in_ready_r <= (fill_next_s != FILL_W'(DEPTH));
    end
  end

  // Issue FSM next-state; RUN0 tolerates one waiting cycle before retiring the instruction
  always_comb begin
    state_next_s    = state_r;
    run_wait_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        state_next_s = RUN0;
      end
      RUN0: begin
        if (!ctrl_waiting) begin
          state_next_s = EXEC;
        end else if (run_wait_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s    = RUN0;
          run_wait_next_s = 1'b1;
        end
      end
      EXEC: begin
        if (ctrl_waiting) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = EXEC;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state, registered status outputs, current instruction and issue counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      run_wait_r     <= 1'b0;
      ctrl_start_r   <= 1'b0;
      busy_r         <= 1'b0;
      cur_instr_r    <= 16'h0000;
      issued_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      run_wait_r   <= run_wait_next_s;
      ctrl_start_r <= (state_next_s == START);
      busy_r       <= (state_next_s != IDLE);
      if (pop_s) begin
        cur_instr_r <= mem_r[rd_ptr_r];
      end
      if (state_r == START) begin
        issued_count_r <= issued_count_r + CNT_W'(1);
      end
    end
  end

  // Register-file address select: Rm, Rd, Rn or R0
  always_comb begin
    r_addr_s = 3'b000;
    case (reg_sel)
      2'b00:   r_addr_s = cur_instr_r[2:0];
      2'b01:   r_addr_s = cur_instr_r[7:5];
      2'b10:   r_addr_s = cur_instr_r[10:8];
      default: r_addr_s = 3'b000;
    endcase
  end

  assign in_ready     = in_ready_r;
  assign ctrl_start   = ctrl_start_r;
  assign busy         = busy_r;
  assign fill         = fill_r;
  assign issued_count = issued_count_r;
  assign r_addr       = r_addr_s;
  assign opcode       = cur_instr_r[15:13];
  assign ALU_op       = cur_instr_r[12:11];
  assign shift_op     = cur_instr_r[4:3];
  assign sximm8       = {{8{cur_instr_r[7]}}, cur_instr_r[7:0]};
  assign sximm5       = {{11{cur_instr_r[4]}}, cur_instr_r[4:0]};

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue; the bench drives ctrl_waiting
// as a simple controller would, with hand-computed expected decode values.
module tb_instr_issue_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [15:0]       in_instr;
  logic              in_ready;
  logic              ctrl_waiting;
  logic [1:0]        reg_sel;
  logic              ctrl_start;
  logic [2:0]        opcode;
  logic [1:0]        ALU_op;
  logic [1:0]        shift_op;
  logic [2:0]        r_addr;
  logic [15:0]       sximm8;
  logic [15:0]       sximm5;
  logic [2:0]        fill;
  logic              busy;
  logic [CNT_W-1:0]  issued_count;

  int n_checks = 0;
  int n_pass   = 0;

  instr_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .ctrl_waiting (ctrl_waiting),
    .reg_sel      (reg_sel),
    .ctrl_start   (ctrl_start),
    .opcode       (opcode),
    .ALU_op       (ALU_op),
    .shift_op     (shift_op),
    .r_addr       (r_addr),
    .sximm8       (sximm8),
    .sximm5       (sximm5),
    .fill         (fill),
    .busy         (busy),
    .issued_count (issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until ctrl_start is observed high
  task automatic wait_start(input string tag);
    int i;
    for (i = 0; i < 8; i++) begin
      if (ctrl_start) break;
      tick();
    end
    chk({tag, "_start_seen"}, {31'd0, ctrl_start}, 32'd1);
  endtask

  // Called in the START cycle: controller runs n EXEC cycles then returns to waiting
  task automatic run_exec(input string tag, input int n);
    ctrl_waiting = 1'b0;
    tick();
    chk({tag, "_pulse_one_cycle"}, {31'd0, ctrl_start}, 32'd0);
    tick();
    repeat (n - 1) tick();
    chk({tag, "_busy_in_exec"}, {31'd0, busy}, 32'd1);
    ctrl_waiting = 1'b1;
    tick();
    chk({tag, "_idle_after_exec"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [15:0] sx8(input logic [15:0] w);
    return {{8{w[7]}}, w[7:0]};
  endfunction

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp_w;
    int accepted;
    int issued;
    int cyc;
    int seen;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_instr     = 16'h0000;
    ctrl_waiting = 1'b1;
    reg_sel      = 2'b00;
    #12;
    chk("rst_fill",     {29'd0, fill}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_start",    {31'd0, ctrl_start}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_count",    {24'd0, issued_count}, 32'd0);
    chk("rst_sximm8",   {16'd0, sximm8}, 32'd0);
    rst_n = 1'b1;
    tick();

    // MOV R1,#5 into an empty queue: start two edges after push
    in_valid = 1'b1;
    in_instr = 16'hD105;
    tick();
    in_valid = 1'b0;
    chk("mov_no_start_yet", {31'd0, ctrl_start}, 32'd0);
    tick();
    chk("mov_start_latency", {31'd0, ctrl_start}, 32'd1);
    chk("mov_opcode", {29'd0, opcode}, 32'd6);
    chk("mov_alu_op", {30'd0, ALU_op}, 32'd2);
    chk("mov_sximm8", {16'd0, sximm8}, 32'h0005);
    chk("mov_sximm5", {16'd0, sximm5}, 32'h0005);
    reg_sel = 2'b10;
    #1;
    chk("mov_r_addr_rn", {29'd0, r_addr}, 32'd1);
    run_exec("mov", 1);
    chk("mov_count", {24'd0, issued_count}, 32'd1);

    // ADD R2,R1,R0 followed back-to-back by 0xD1F0
    in_valid = 1'b1;
    in_instr = 16'hA140;
    tick();
    in_instr = 16'hD1F0;
    tick();
    in_valid = 1'b0;
    chk("add_start", {31'd0, ctrl_start}, 32'd1);
    chk("add_second_queued", {29'd0, fill}, 32'd1);
    chk("add_opcode", {29'd0, opcode}, 32'd5);
    reg_sel = 2'b00;
    #1;
    chk("add_r_addr_rm", {29'd0, r_addr}, 32'd0);
    reg_sel = 2'b01;
    #1;
    chk("add_r_addr_rd", {29'd0, r_addr}, 32'd2);
    reg_sel = 2'b10;
    #1;
    chk("add_r_addr_rn", {29'd0, r_addr}, 32'd1);
    run_exec("add", 4);
    chk("add_second_still_queued", {29'd0, fill}, 32'd1);
    chk("add_stable_opcode", {29'd0, opcode}, 32'd5);
    tick();
    chk("neg_start_next_cycle", {31'd0, ctrl_start}, 32'd1);
    chk("neg_sximm8", {16'd0, sximm8}, 32'hFFF0);
    run_exec("neg", 1);
    chk("add_count", {24'd0, issued_count}, 32'd3);

    // Fill with the controller busy; fifth word must be dropped
    ctrl_waiting = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      in_valid = 1'b1;
      in_instr = 16'hD100 | 16'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("full_fill", {29'd0, fill}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    ctrl_waiting = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      wait_start("fifo_order");
      chk("fifo_order_sximm8", {16'd0, sximm8}, 32'(k));
      run_exec("fifo_order", 1);
    end
    seen = 0;
    repeat (4) begin
      tick();
      if (ctrl_start) seen++;
    end
    chk("full_no_extra_issue", 32'(seen), 32'd0);
    chk("full_fill_empty", {29'd0, fill}, 32'd0);
    chk("full_count", {24'd0, issued_count}, 32'd7);

    // Unsupported opcode: START, RUN0, RUN0, IDLE, then next entry issues
    in_valid = 1'b1;
    in_instr = 16'h0000;
    tick();
    in_instr = 16'hD107;
    tick();
    in_valid = 1'b0;
    chk("unsup_start", {31'd0, ctrl_start}, 32'd1);
    tick();
    chk("unsup_run0_a", {30'd0, ctrl_start, busy}, 32'd1);
    tick();
    chk("unsup_run0_b", {30'd0, ctrl_start, busy}, 32'd1);
    tick();
    chk("unsup_idle", {30'd0, ctrl_start, busy}, 32'd0);
    chk("unsup_count", {24'd0, issued_count}, 32'd8);
    tick();
    chk("unsup_next_start", {31'd0, ctrl_start}, 32'd1);
    chk("unsup_next_sximm8", {16'd0, sximm8}, 32'h0007);
    run_exec("unsup_next", 2);
    chk("unsup_next_count", {24'd0, issued_count}, 32'd9);

    // Asynchronous reset in the middle of EXEC with an entry still queued
    in_valid = 1'b1;
    in_instr = 16'hD1AA;
    tick();
    in_instr = 16'hD1BB;
    tick();
    in_valid = 1'b0;
    ctrl_waiting = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_start", {31'd0, ctrl_start}, 32'd0);
    chk("arst_fill", {29'd0, fill}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_opcode", {29'd0, opcode}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_count", {24'd0, issued_count}, 32'd0);
    ctrl_waiting = 1'b1;
    rst_n = 1'b1;
    seen = 0;
    repeat (3) begin
      tick();
      if (ctrl_start) seen++;
    end
    chk("arst_queue_discarded", 32'(seen), 32'd0);

    // Issue 2^CNT_W+3 words through the queue; counter wraps, order preserved
    accepted = 0;
    issued   = 0;
    cyc      = 0;
    while (issued < 259 && cyc < 3000) begin
      in_valid = (accepted < 259);
      in_instr = {8'h00, 8'(accepted)};
      if (in_valid && in_ready) begin
        q.push_back(in_instr);
        accepted++;
      end
      tick();
      cyc++;
      if (ctrl_start) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 16'hDEAD;
        chk("wrap_order", {16'd0, sximm8}, {16'd0, sx8(exp_w)});
        issued++;
      end
    end
    in_valid = 1'b0;
    chk("wrap_issued_all", 32'(issued), 32'd259);
    tick();
    chk("wrap_count", {24'd0, issued_count}, 32'd3);
    repeat (4) tick();
    chk("wrap_fill_empty", {29'd0, fill}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
